// File: rtl/spi_flash_read_seq.sv
// Serial-flash READ sequencer driving an spi_master byte engine: cmd, 24-bit address,
// optional dummy byte, then N data bytes in one CS-low frame. Define FAST_READ_EN for fast read.
module spi_flash_read_seq #(
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter logic [7:0] FAST_CMD  = 8'h0B,
    parameter logic [7:0] FILL_BYTE = 8'hFF,
    parameter int         LEN_W     = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] length,
    output logic             ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             spi_enabled,
    output logic [7:0]       spi_data_in,
    output logic             spi_continue_rw,
    input  logic             spi_busy,
    input  logic [7:0]       spi_data_out
);

`ifdef FAST_READ_EN
    localparam bit FAST_SEL = 1'b1;
    localparam logic [2:0] HDR = 3'd5;
`else
    localparam bit FAST_SEL = 1'b0;
    localparam logic [2:0] HDR = 3'd4;
`endif
    localparam logic [7:0] CMD_BYTE = FAST_SEL ? FAST_CMD : READ_CMD;

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_FINISH} state_t;

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             done_q, done_d;
    logic             spi_enabled_q, spi_enabled_d;
    logic [7:0]       spi_data_in_q, spi_data_in_d;
    logic             spi_continue_rw_q, spi_continue_rw_d;
    logic             busy_dly_q, busy_dly_d;
    logic [2:0]       hdr_idx_q, hdr_idx_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [23:0]      addr_q, addr_d;
    logic [7:0]       hdr_next;
    logic             byte_done;

    // hdr_idx_q is the header byte currently on the wire; HDR means data phase
    always_comb begin
        hdr_next = FILL_BYTE;
        case (hdr_idx_q)
            3'd0:    hdr_next = addr_q[23:16];
            3'd1:    hdr_next = addr_q[15:8];
            3'd2:    hdr_next = addr_q[7:0];
`ifdef FAST_READ_EN
            3'd3:    hdr_next = 8'h00;
`endif
            default: hdr_next = FILL_BYTE;
        endcase
    end

    assign byte_done = busy_dly_q && !spi_busy;

    always_comb begin
        state_d           = state_q;
        ready_d           = ready_q;
        rd_data_d         = rd_data_q;
        rd_valid_d        = 1'b0;
        done_d            = 1'b0;
        spi_enabled_d     = spi_enabled_q;
        spi_data_in_d     = spi_data_in_q;
        spi_continue_rw_d = 1'b0;
        busy_dly_d        = spi_busy;
        hdr_idx_d         = hdr_idx_q;
        rem_d             = rem_q;
        addr_d            = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d        = addr;
                        rem_d         = length;
                        hdr_idx_d     = 3'd0;
                        spi_data_in_d = CMD_BYTE;
                        spi_enabled_d = 1'b1;
                        ready_d       = 1'b0;
                        state_d       = ST_XFER;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                if (byte_done) begin
                    if (hdr_idx_q == HDR) begin
                        rd_data_d  = spi_data_out;
                        rd_valid_d = 1'b1;
                    end
                    // rem_q counts data bytes not yet started, so a full-scale length never wraps
                    if (hdr_idx_q < HDR - 3'd1) begin
                        spi_data_in_d     = hdr_next;
                        spi_continue_rw_d = 1'b1;
                        hdr_idx_d         = hdr_idx_q + 3'd1;
                    end else if (rem_q != '0) begin
                        spi_data_in_d     = FILL_BYTE;
                        spi_continue_rw_d = 1'b1;
                        rem_d             = rem_q - LEN_W'(1);
                        hdr_idx_d         = HDR;
                    end else begin
                        spi_enabled_d = 1'b0;
                        state_d       = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                spi_enabled_d = 1'b0;
                ready_d       = 1'b1;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            ready_q           <= 1'b1;
            rd_data_q         <= 8'h00;
            rd_valid_q        <= 1'b0;
            done_q            <= 1'b0;
            spi_enabled_q     <= 1'b0;
            spi_data_in_q     <= 8'hFF;
            spi_continue_rw_q <= 1'b0;
            busy_dly_q        <= 1'b0;
            hdr_idx_q         <= 3'd0;
            rem_q             <= '0;
            addr_q            <= 24'h000000;
        end else begin
            state_q           <= state_d;
            ready_q           <= ready_d;
            rd_data_q         <= rd_data_d;
            rd_valid_q        <= rd_valid_d;
            done_q            <= done_d;
            spi_enabled_q     <= spi_enabled_d;
            spi_data_in_q     <= spi_data_in_d;
            spi_continue_rw_q <= spi_continue_rw_d;
            busy_dly_q        <= busy_dly_d;
            hdr_idx_q         <= hdr_idx_d;
            rem_q             <= rem_d;
            addr_q            <= addr_d;
        end
    end

    assign ready           = ready_q;
    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;
    assign done            = done_q;
    assign spi_enabled     = spi_enabled_q;
    assign spi_data_in     = spi_data_in_q;
    assign spi_continue_rw = spi_continue_rw_q;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Bench for spi_flash_read_seq: behavioural SPI engine + flash model, scoreboarded MOSI and read data.
// Build with FAST_READ_EN defined to exercise the fast-read header.
module tb_spi_flash_read_seq;

`ifdef FAST_READ_EN
    localparam int HDR = 5;
    localparam logic [7:0] CMD = 8'h0B;
`else
    localparam int HDR = 4;
    localparam logic [7:0] CMD = 8'h03;
`endif

    logic        clk_in = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] addr;
    logic [15:0] length;
    logic        ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        spi_enabled;
    logic [7:0]  spi_data_in;
    logic        spi_continue_rw;
    logic        spi_busy = 1'b0;
    logic [7:0]  spi_data_out = 8'h00;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_rd_q[$];
    logic [7:0] exp_mosi_q[$];

    spi_flash_read_seq dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .start           (start),
        .addr            (addr),
        .length          (length),
        .ready           (ready),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .done            (done),
        .spi_enabled     (spi_enabled),
        .spi_data_in     (spi_data_in),
        .spi_continue_rw (spi_continue_rw),
        .spi_busy        (spi_busy),
        .spi_data_out    (spi_data_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine model: 4-cycle busy per byte, aborts when enabled drops; flash answers per frame position
    int         eng_cnt = 0;
    int         eng_frame_idx = 0;
    logic       eng_in_frame = 1'b0;
    logic       tx_strobe = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic [7:0] eng_resp = 8'h00;
    logic [7:0] frame_bytes [0:3];

    always @(posedge clk_in) begin
        if (spi_enabled !== 1'b1) begin
            spi_busy      <= 1'b0;
            eng_in_frame  <= 1'b0;
            eng_cnt       <= 0;
            eng_frame_idx <= 0;
            tx_strobe     <= 1'b0;
        end else begin
            tx_strobe <= 1'b0;
            if (spi_busy) begin
                if (eng_cnt == 0) begin
                    spi_busy     <= 1'b0;
                    spi_data_out <= eng_resp;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end else if (!eng_in_frame || spi_continue_rw) begin
                eng_in_frame  <= 1'b1;
                spi_busy      <= 1'b1;
                eng_cnt       <= 3;
                tx_byte       <= spi_data_in;
                tx_strobe     <= 1'b1;
                eng_frame_idx <= eng_frame_idx + 1;
                if (eng_frame_idx < 4) frame_bytes[eng_frame_idx] <= spi_data_in;
                if (eng_frame_idx < HDR) eng_resp <= 8'hC3;
                else eng_resp <= mem_byte({frame_bytes[1], frame_bytes[2], frame_bytes[3]}
                                          + 24'(eng_frame_idx - HDR));
            end
        end
    end

    // Monitor: sampled on the falling edge, away from DUT updates
    int   cycle = 0;
    int   rd_count = 0;
    int   done_count = 0;
    int   cont_count = 0;
    int   cont_run = 0;
    int   en_rise = 0;
    int   last_bdone = -100;
    logic prev_busy = 1'b0;
    logic prev_en = 1'b0;
    logic check_lat = 1'b0;

    always @(negedge clk_in) begin
        cycle++;
        if (prev_busy && !spi_busy) last_bdone = cycle;
        prev_busy = spi_busy;
        if (spi_enabled === 1'b1 && !prev_en) en_rise++;
        prev_en = (spi_enabled === 1'b1);
        if (tx_strobe) begin
            if (exp_mosi_q.size() == 0) checkOutput("mosiExtra", exp_mosi_q.size(), 1);
            else checkOutput("mosi", tx_byte, exp_mosi_q.pop_front());
        end
        if (rd_valid === 1'b1) begin
            rd_count++;
            checkOutput("rdLatency", cycle - last_bdone, 1);
            if (exp_rd_q.size() == 0) checkOutput("rdExtra", exp_rd_q.size(), 1);
            else checkOutput("rdData", rd_data, exp_rd_q.pop_front());
        end
        if (done === 1'b1) begin
            done_count++;
            if (check_lat) checkOutput("doneLatency", cycle - last_bdone, 2);
        end
        if (spi_continue_rw === 1'b1) begin
            if (cont_run == 0) cont_count++;
            cont_run++;
        end else if (cont_run != 0) begin
            checkOutput("contWidth", cont_run, 1);
            cont_run = 0;
        end
    end

    // Drives one start request and pushes the expected MOSI stream and read data
    task automatic applyStimulus(input logic [23:0] a, input logic [15:0] len);
        @(negedge clk_in);
        if (len != 0) begin
            exp_mosi_q.push_back(CMD);
            exp_mosi_q.push_back(a[23:16]);
            exp_mosi_q.push_back(a[15:8]);
            exp_mosi_q.push_back(a[7:0]);
            if (HDR == 5) exp_mosi_q.push_back(8'h00);
            for (int i = 0; i < len; i++) begin
                exp_mosi_q.push_back(8'hFF);
                exp_rd_q.push_back(mem_byte(a + 24'(i)));
            end
        end
        check_lat = (len != 0);
        addr   = a;
        length = len;
        start  = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        if (len != 0) begin
            checkOutput("enLatency", spi_enabled, 1);
            checkOutput("readyBusy", ready, 0);
        end else begin
            checkOutput("zeroDone", done, 1);
            checkOutput("zeroReady", ready, 1);
        end
    endtask

    task automatic waitDone(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_in);
            if (done === 1'b1) seen = 1'b1;
        end
        checkOutput("doneSeen", seen, 1);
    endtask

    // Full transaction with end-of-transaction bookkeeping checks
    task automatic runTxn(input string tag, input logic [23:0] a, input logic [15:0] len);
        int rd0 = rd_count;
        int ct0 = cont_count;
        int en0 = en_rise;
        applyStimulus(a, len);
        waitDone(2000);
        @(negedge clk_in);
        checkOutput({tag, ".rdCount"}, rd_count - rd0, len);
        checkOutput({tag, ".contPulses"}, cont_count - ct0, HDR + len - 1);
        checkOutput({tag, ".frames"}, en_rise - en0, 1);
        checkOutput({tag, ".mosiLeft"}, exp_mosi_q.size(), 0);
        checkOutput({tag, ".rdLeft"}, exp_rd_q.size(), 0);
        checkOutput({tag, ".ready"}, ready, 1);
        checkOutput({tag, ".enLow"}, spi_enabled, 0);
    endtask

    initial begin
        int rd0, dn0, en0, ct0;
        bit reached;
        reset  = 1'b1;
        start  = 1'b0;
        addr   = 24'h0;
        length = 16'h0;
        repeat (3) @(negedge clk_in);
        checkOutput("rstReady", ready, 1);
        checkOutput("rstRdData", rd_data, 8'h00);
        checkOutput("rstRdValid", rd_valid, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstEnabled", spi_enabled, 0);
        checkOutput("rstDataIn", spi_data_in, 8'hFF);
        checkOutput("rstCont", spi_continue_rw, 0);
        reset = 1'b0;
        @(negedge clk_in);

        runTxn("single", 24'h123456, 16'd1);
        runTxn("wrap", 24'hFFFFFE, 16'd4);
        runTxn("fast", 24'h000010, 16'd2);

        // Zero length: done the cycle after start, no frame
        en0 = en_rise;
        dn0 = done_count;
        applyStimulus(24'h000100, 16'd0);
        repeat (10) @(negedge clk_in);
        checkOutput("zeroFrames", en_rise - en0, 0);
        checkOutput("zeroDoneCount", done_count - dn0, 1);

        // Start and address changes while busy are ignored
        rd0 = rd_count;
        en0 = en_rise;
        dn0 = done_count;
        applyStimulus(24'h00A5C0, 16'd2);
        repeat (6) @(negedge clk_in);
        addr   = 24'h999999;
        length = 16'd5;
        start  = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        waitDone(2000);
        repeat (4) @(negedge clk_in);
        checkOutput("busyStart.rd", rd_count - rd0, 2);
        checkOutput("busyStart.frames", en_rise - en0, 1);
        checkOutput("busyStart.done", done_count - dn0, 1);
        checkOutput("busyStart.mosiLeft", exp_mosi_q.size(), 0);

        // Reset after the second address byte abandons the transaction
        applyStimulus(24'hABCDEF, 16'd3);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk_in);
            if (eng_frame_idx >= 3) reached = 1'b1;
        end
        checkOutput("rstMid.reached", reached, 1);
        repeat (2) @(negedge clk_in);
        rd0 = rd_count;
        dn0 = done_count;
        reset = 1'b1;
        @(negedge clk_in);
        checkOutput("rstMid.enabled", spi_enabled, 0);
        checkOutput("rstMid.ready", ready, 1);
        reset = 1'b0;
        exp_mosi_q.delete();
        exp_rd_q.delete();
        repeat (20) @(negedge clk_in);
        checkOutput("rstMid.noRd", rd_count - rd0, 0);
        checkOutput("rstMid.noDone", done_count - dn0, 0);
        runTxn("afterRst", 24'h00F0F0, 16'd3);

        ct0 = tests_failed;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        if (ct0 < 0) $display("[TB] unreachable");
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/spi_flash_read_seq.md
Name: spi_flash_read_seq

Overview:
- Byte-level sequencer that sits directly upstream of the SPI byte engine (spi_master) and drives its enable/data/continue handshake.
- Performs a complete serial-flash READ transaction from a single start request: command byte, 24-bit address (MSB first), optional dummy byte, then N data bytes, all inside one CS-low frame.
- Presents received data as a byte stream with a one-cycle valid strobe to the consumer, which is the FPGA configuration/calibration loader.

Parameters:
- READ_CMD, 8'h03, command byte for normal read.
- FAST_CMD, 8'h0B, command byte for fast read (used only with FAST_READ_EN).
- FILL_BYTE, 8'hFF, byte driven on MOSI during data phase.
- LEN_W, 16, width of the byte-count input.

Ports:
- clk_in  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when ready=1.
- addr  in  24  flash start address; latched on accepted start.
- length  in  LEN_W  number of data bytes; latched on accepted start.
- ready  out  1  high in IDLE only.
- rd_data  out  8  received data byte.
- rd_valid  out  1  one-cycle strobe; rd_data valid while high.
- done  out  1  one-cycle strobe at end of transaction.
- spi_enabled  out  1  to engine enabled; high for the whole CS-low frame.
- spi_data_in  out  8  to engine data_in; byte to transmit.
- spi_continue_rw  out  1  to engine continue_rw; one-cycle pulse to start the 2nd and later bytes.
- spi_busy  in  1  from engine busy.
- spi_data_out  in  8  from engine data_out.

Behaviour:
- All outputs registered.
- Reset values: ready=1, rd_data=0, rd_valid=0, done=0, spi_enabled=0, spi_data_in=8'hFF, spi_continue_rw=0. Internal busy_d=0 and counters=0.
- Engine contract:
  - First byte of a frame: raise spi_enabled with spi_continue_rw=0 and spi_data_in already valid.
  - Byte complete (byte_done) = busy_d==1 && spi_busy==0; busy_d is spi_busy delayed one clock. spi_data_out is valid in the byte_done cycle.
  - Each further byte: load spi_data_in and pulse spi_continue_rw for exactly 1 cycle, registered on byte_done.
  - spi_enabled=0 ends the frame (CS high).
- Byte order: cmd, addr[23:16], addr[15:8], addr[7:0], [dummy 8'h00 if FAST_READ_EN], then `length` bytes of FILL_BYTE. Header bytes are HDR = 4 (or 5).
- States:
  - IDLE: ready=1.
    - start & length!=0: latch addr/length, spi_data_in<=cmd, spi_enabled<=1, ready<=0, goto XFER.
    - start & length==0: done<=1 next cycle, no frame, stay IDLE.
  - XFER: byte_idx counts transmitted bytes. On byte_done:
    - If byte_idx>=HDR: rd_data<=spi_data_out, rd_valid<=1.
    - If bytes remain: spi_data_in<=next byte, spi_continue_rw<=1, byte_idx++.
    - Else: spi_enabled<=0, goto FINISH.
    - spi_continue_rw auto-clears the following cycle.
  - FINISH: done<=1, ready<=1, goto IDLE. spi_enabled stays 0 for ≥1 cycle before any new frame.
- Header-phase received bytes are discarded (no rd_valid).
- Remaining-data counter is LEN_W wide. length = 2^LEN_W-1 works without wrap.
- start while ready=0 is ignored.
- reset mid-frame: spi_enabled drops in the same edge, the transaction is abandoned, no done and no rd_valid.
- Latency:
  - start to spi_enabled high: 1 clk.
  - byte_done to rd_valid: 1 clk.
  - Last byte_done to done: 2 clk.

Optional Feature:
- FAST_READ_EN defined: command = FAST_CMD, one 8'h00 dummy byte inserted after the address, HDR=5, the dummy's received byte is discarded.
- FAST_READ_EN undefined: command = READ_CMD, HDR=4, no dummy logic synthesized.

Test Plan:
- Behavioural engine + flash model, addr=24'h123456, length=1 -> MOSI bytes 03 12 34 56 FF in one CS-low frame; exactly 1 rd_valid with rd_data=mem[0x123456]; done 2 clks after last byte_done; ready back to 1.
- length=4 at addr 24'hFFFFFE (model wraps) -> 4 rd_valid pulses, data mem[FFFFFE], mem[FFFFFF], mem[0], mem[1]; spi_continue_rw pulses exactly 7 times, each 1 cycle wide.
- length=0 -> done the cycle after start; spi_enabled never rises.
- start re-asserted during XFER -> ignored; addr change after accept has no effect on MOSI.
- reset asserted after the 2nd address byte -> next clk spi_enabled=0, ready=1, no done/rd_valid; a following start runs a full, correct transaction.
- FAST_READ_EN build, addr=24'h000010, length=2 -> MOSI 0B 00 00 10 00 FF FF; 2 rd_valid only.
